// File: rtl/deser_pkg.sv
// Shared definitions for the 16-bit serial link receiver.
//   state_e         : receiver FSM states (HUNT = waiting for alignment, SHIFT = assembling)
//   DESER_WIDTH_DEF : default frame width in bits
//   cnt_width()     : width of the bit counter for a given frame width
package deser_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DESER_WIDTH_DEF = 16;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-deep valid/ready holding register for assembled words.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : a new word is complete this cycle
//   load_data  : the completed word
//   out_ready  : consumer accepts out_data when out_valid && out_ready
//   out_data   : held word, stable while out_valid=1 and out_ready=0
//   out_valid  : register full
//   drop       : sticky; a completed word arrived while the register was full and not consumed
module deser_out_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             drop
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (load) begin
      if (!valid_q || out_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign drop      = drop_q;

endmodule

// File: rtl/deserializer_16.sv
// Receive end of the 16-bit serial link: samples an MSB-first bit stream one bit per clk
// and rebuilds WIDTH-bit words into a 1-deep valid/ready holding register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   ser_in     : serial data, sampled every posedge
//   sync       : high in the cycle ser_in carries a frame MSB
//   out_data   : assembled word (valid while out_valid=1)
//   out_valid  : holding register full
//   out_ready  : consumer handshake
//   overflow   : sticky, a completed word was dropped
//   sync_err   : 1-cycle pulse, sync arrived mid-frame and forced a realign
// Build option:
//   DESER_FREE_RUN_EN : alignment comes from reset release instead of sync; sync is ignored,
//                       sync_err stays 0, and FIRST_BIT_DELAY samples are skipped after reset.
module deserializer_16
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH           = DESER_WIDTH_DEF,
  parameter int unsigned FIRST_BIT_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             sync_err
);

  // The counter also times the free-run start delay, so size it for the larger of the two.
  localparam int unsigned MAXW = (WIDTH > FIRST_BIT_DELAY) ? WIDTH : FIRST_BIT_DELAY;
  localparam int unsigned CW   = cnt_width(MAXW);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds the WIDTH-1 bits received before the completing bit, right-justified; the
  // completing bit goes straight from ser_in into the word, so the register never needs
  // to store a full word.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic             sync_err_q, sync_err_d;
  logic             load;
  logic [WIDTH-1:0] load_data;

  assign load_data = {shift_q, ser_in};

`ifdef DESER_FREE_RUN_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(FIRST_BIT_DELAY - 1);

  logic unused_sync;
  assign unused_sync = sync;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sync_err_d = 1'b0;
    load       = 1'b0;
    case (state_q)
      // HUNT counts the samples skipped after reset release.
      HUNT: begin
        if (cnt_q == DLY_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-3:0], ser_in};
        if (cnt_q == LAST) begin
          cnt_d = '0;
          load  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end
`else
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sync_err_d = 1'b0;
    load       = 1'b0;
    case (state_q)
      HUNT: begin
        if (sync) begin
          state_d = SHIFT;
          shift_d = {{(WIDTH-2){1'b0}}, ser_in};
          cnt_d   = CW'(1);
        end
      end
      SHIFT: begin
        if (sync && (cnt_q != '0)) begin
          // Mid-frame sync (including on the completing bit): drop the partial word and
          // restart the frame with this sample as its MSB.
          shift_d    = {{(WIDTH-2){1'b0}}, ser_in};
          cnt_d      = CW'(1);
          sync_err_d = 1'b1;
        end else begin
          shift_d = {shift_q[WIDTH-3:0], ser_in};
          if (cnt_q == LAST) begin
            cnt_d = '0;
            load  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      shift_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;

  deser_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .drop      (overflow)
  );

endmodule

// File: tb/tb_deserializer_16.sv
// Self-checking bench for deserializer_16 (sync-aligned build, or free-run build when
// DESER_FREE_RUN_EN is defined).
module tb_deserializer_16;

  localparam int FBD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_in = 1'b0;
  logic        sync = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        overflow;
  logic        sync_err;

  deserializer_16 #(
    .WIDTH           (16),
    .FIRST_BIT_DELAY (FBD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .sync      (sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: frame position as an integer, word built arithmetically.
  logic [15:0] m_data;
  logic        m_valid, m_ovf, m_serr;
  bit          m_al;
  int          m_pos, m_dly;
  logic [15:0] m_word;

  always @(posedge clk) begin : model
    bit done;
    bit take;
    cyc++;
    if (rst) begin
      m_data = '0; m_valid = 0; m_ovf = 0; m_serr = 0;
      m_al = 0; m_pos = 0; m_dly = 0; m_word = '0;
    end else begin
      done = 0;
      take = 0;
      m_serr = 0;
`ifdef DESER_FREE_RUN_EN
      if (!m_al) begin
        m_dly++;
        if (m_dly == FBD) begin m_al = 1; m_pos = 0; end
      end else take = 1;
`else
      if (!m_al) begin
        if (sync) begin m_al = 1; m_pos = 1; m_word = {15'd0, ser_in}; end
      end else if (sync && m_pos != 0) begin
        m_serr = 1; m_pos = 1; m_word = {15'd0, ser_in};
      end else take = 1;
`endif
      if (take) begin
        if (m_pos == 0) m_word = {15'd0, ser_in};
        else            m_word = 16'((m_word * 2) + ser_in);
        m_pos++;
        if (m_pos == 16) begin m_pos = 0; done = 1; end
      end
      if (done) begin
        if (!m_valid || out_ready) begin m_data = m_word; m_valid = 1; end
        else m_ovf = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out_data",  {16'd0, out_data}, {16'd0, m_data});
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("model_overflow",  {31'd0, overflow},  {31'd0, m_ovf});
      chk("model_sync_err",  {31'd0, sync_err},  {31'd0, m_serr});
    end
  end

  // Accepted-word log and sync_err pulse counter.
  logic [15:0] log_d[$];
  int          log_c[$];
  int          serr_cnt = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      log_d.push_back(out_data);
      log_c.push_back(cyc);
    end
  end

  always @(negedge clk) if (sync_err === 1'b1) serr_cnt++;

  task automatic drive_bit(input logic b, input logic s);
    @(negedge clk);
    ser_in = b;
    sync   = s;
  endtask

  task automatic send_word(input logic [15:0] w, input logic s_msb);
    for (int i = 15; i >= 0; i--) drive_bit(w[i], s_msb && (i == 15));
  endtask

  task automatic clear_logs();
    log_d.delete();
    log_c.delete();
    serr_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sync = 1'b0; ser_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] frame;
    logic [8:0]  part;
    do_reset();
    chk("reset_out_data",  {16'd0, out_data}, 32'h0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'h0);
    chk("reset_overflow",  {31'd0, overflow},  32'h0);
    chk("reset_sync_err",  {31'd0, sync_err},  32'h0);

`ifdef DESER_FREE_RUN_EN
    // Serializer with registered output reset on the same edge: its output is 0 on the
    // first sample after reset release, then the MSB onward.
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b1; ser_in = 1'b0;
    @(negedge clk); rst = 1'b0; ser_in = 1'b0;
    clear_logs();
    frame = 16'hC0DE;
    for (int f = 0; f < 4; f++)
      for (int i = 15; i >= 0; i--) drive_bit(frame[i], 1'($urandom_range(0, 1)));
    drive_bit(frame[15], 1'b1);
    drive_bit(frame[14], 1'b0);
    chk("fr_count", log_d.size(), 4);
    for (int k = 0; k < 4; k++) chk("fr_data", {16'd0, log_d[k]}, 32'hC0DE);
    for (int k = 1; k < 4; k++) chk("fr_spacing", log_c[k] - log_c[k-1], 16);
    chk("fr_no_sync_err", serr_cnt, 0);
    // Stall the consumer across two more frames to force an overflow.
    out_ready = 1'b0;
    for (int i = 13; i >= 0; i--) drive_bit(frame[i], 1'b1);
    send_word(frame, 1'b0);
    send_word(frame, 1'b1);
    @(negedge clk);
    chk("fr_ovf_valid", {31'd0, out_valid}, 32'h1);
    chk("fr_ovf_data",  {16'd0, out_data},  32'hC0DE);
    chk("fr_overflow",  {31'd0, overflow},  32'h1);
`else
    // 1: single frame, latency one cycle after LSB.
    out_ready = 1'b1;
    send_word(16'hA5C3, 1'b1);
    @(negedge clk);
    chk("t1_valid",    {31'd0, out_valid}, 32'h1);
    chk("t1_data",     {16'd0, out_data},  32'hA5C3);
    chk("t1_sync_err", {31'd0, sync_err},  32'h0);
    @(negedge clk);
    chk("t1_valid_clear", {31'd0, out_valid}, 32'h0);

    // 2: back-to-back frames.
    do_reset();
    out_ready = 1'b1;
    send_word(16'h1234, 1'b1);
    send_word(16'hFFFF, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("t2_count",   log_d.size(), 2);
    chk("t2_word0",   {16'd0, log_d[0]}, 32'h1234);
    chk("t2_word1",   {16'd0, log_d[1]}, 32'hFFFF);
    chk("t2_spacing", log_c[1] - log_c[0], 16);
    chk("t2_overflow", {31'd0, overflow}, 32'h0);

    // 3: stalled consumer, overflow, then drain.
    do_reset();
    out_ready = 1'b0;
    send_word(16'h0001, 1'b1);
    send_word(16'h0002, 1'b1);
    send_word(16'h0003, 1'b1);
    @(negedge clk);
    chk("t3_valid",    {31'd0, out_valid}, 32'h1);
    chk("t3_data",     {16'd0, out_data},  32'h0001);
    chk("t3_overflow", {31'd0, overflow},  32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_drained",  {31'd0, out_valid}, 32'h0);
    chk("t3_count",    log_d.size(), 1);
    chk("t3_word",     {16'd0, log_d[0]}, 32'h0001);
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'h1);

    // 4: realign at bit_cnt=7.
    do_reset();
    out_ready = 1'b1;
    frame = 16'h00B3;
    for (int i = 0; i < 7; i++) drive_bit(frame[i], i == 0);
    send_word(16'hBEEF, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("t4_serr_pulses", serr_cnt, 1);
    chk("t4_count", log_d.size(), 1);
    chk("t4_word",  {16'd0, log_d[0]}, 32'hBEEF);

    // 5: reset mid-frame with a held word and overflow set, then HUNT ignores data.
    do_reset();
    out_ready = 1'b0;
    send_word(16'h1111, 1'b1);
    send_word(16'h2222, 1'b1);
    part = 9'h1AB;
    for (int i = 8; i >= 0; i--) drive_bit(part[i], i == 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_data",  {16'd0, out_data},  32'h0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'h0);
    chk("t5_rst_ovf",   {31'd0, overflow},  32'h0);
    chk("t5_rst_serr",  {31'd0, sync_err},  32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 20; i++) drive_bit(1'((i * 7 + 3) % 5 < 2), 1'b0);
    @(negedge clk);
    chk("t5_hunt_valid", {31'd0, out_valid}, 32'h0);
    chk("t5_hunt_count", log_d.size(), 0);
    send_word(16'h5A5A, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("t5_count", log_d.size(), 1);
    chk("t5_word",  {16'd0, log_d[0]}, 32'h5A5A);

    // Sync on the completing bit: no word, one sync_err.
    do_reset();
    out_ready = 1'b1;
    frame = 16'h8421;
    for (int i = 15; i >= 1; i--) drive_bit(frame[i], i == 15);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("t7_serr_pulses", serr_cnt, 1);
    chk("t7_count", log_d.size(), 0);
`endif

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
